adc_sequencer: RTL and testbench
================================

Name: adc_sequencer

Overview:
- Sequences the dual-slope ADC front end. Issues periodic conversion-start pulses to the ADC controller and supervises each conversion with a watchdog.
- Auto-ranges the down-ramp time with a shift so the downstream time-to-temp stage always sees an in-window value. This replaces the manual switch-driven shift.
- Sits between adc_controller (start/eoc/down_ramp_time) and time_to_temp (start/down_ramp_time).

Parameters:
- PERIOD, 650000: cycles from one conversion start to the next (10 ms at 65 MHz); minimum 16.
- TIMEOUT, 1300000: cycles allowed from start_conv to conv_done before a timeout is declared.
- HI_LIMIT, 1023: shifted value above this triggers range up.
- LO_LIMIT, 240: shifted value below this triggers range down.
- MAX_RETRY, 3: maximum re-range retries per sample.

Ports:
- clk  input  1  system clock (65 MHz domain)
- reset  input  1  asynchronous, active-high; clears all state
- enable  input  1  level; 1 = run periodic conversions
- err_clear  input  1  single-cycle pulse; clears timeout_fault
- conv_done  input  1  single-cycle end-of-conversion pulse from ADC controller
- down_ramp_time  input  20  raw down-ramp count, valid when conv_done=1
- start_conv  output  1  single-cycle pulse; starts one ADC conversion
- sample  output  20  down_ramp_time >> range_shift, registered
- sample_valid  output  1  single-cycle pulse; sample is valid (drives time_to_temp start)
- range_shift  output  2  current shift amount, 0..3
- range_sat  output  1  registered with sample; 1 = sample taken at shift 0 below LO_LIMIT, at shift 3 above HI_LIMIT, or after retries were exhausted
- timeout_fault  output  1  sticky; set on watchdog expiry
- busy  output  1  1 while in START, CONVERT or CHECK

Behaviour:
- Reset values:
  - start_conv=0, sample=0, sample_valid=0, range_shift=0.
  - range_sat=0, timeout_fault=0, busy=0.
  - State IDLE; all counters 0.
- States: IDLE, WAIT, START, CONVERT, CHECK.
- IDLE: waits for enable=1. On the next cycle goes to START with the period counter cleared.
- Period counter: free-runs from each START entry and wraps at PERIOD-1. WAIT exits to START when the counter equals PERIOD-1, so starts are exactly PERIOD cycles apart unless a retry intervenes.
- START: asserts start_conv for exactly one cycle, clears the watchdog, then goes to CONVERT.
- CONVERT:
  - On conv_done=1, latches down_ramp_time and goes to CHECK.
  - If the watchdog reaches TIMEOUT-1 with no conv_done: sets timeout_fault, resets the retry count, goes to WAIT. No sample is produced.
  - A conv_done outside CONVERT is ignored.
- CHECK (one cycle): s = latched >> range_shift.
  - If s > HI_LIMIT, range_shift < 3 and retry < MAX_RETRY: range_shift+1, retry+1, go to START immediately (no sample).
  - Else if s < LO_LIMIT, range_shift > 0 and retry < MAX_RETRY: range_shift-1, retry+1, go to START.
  - Else: sample <= s and sample_valid pulses 1 cycle. range_sat <= 1 if s is still out of window, else 0. Retry resets to 0; go to WAIT.
- Latency: sample_valid occurs 2 cycles after the conv_done cycle (latch cycle, then CHECK register).
- Hysteresis: LO_LIMIT < HI_LIMIT/2 guarantees that one shift step never oscillates.
- enable deasserted: the current conversion, including retries, completes normally; the FSM then returns to IDLE instead of WAIT. range_shift is retained.
- timeout_fault: cleared only by err_clear or reset. If err_clear and a new timeout occur in the same cycle, set wins.
- Reset mid-conversion: state, counters and outputs return to reset values immediately (asynchronous). A late conv_done after reset is ignored because the FSM is not in CONVERT.
- All counters are 21 bits wide, unsigned. Shift arithmetic is a logical right shift with zero fill.

Test Plan:
- Enable with PERIOD=100 and a model replying conv_done 50 cycles after each start with down_ramp_time=500 -> start_conv every 100 cycles, sample=500 and sample_valid 2 cycles after each conv_done, range_shift=0, range_sat=0.
- Model returns 3000 then 1500 -> first CHECK bumps range_shift to 1 and restarts with no sample; second gives sample=750, range_shift=1.
- Model always returns 0xFFFFF, MAX_RETRY=3 -> range_shift steps 1, 2, 3, then sample=0x1FFFF with range_sat=1 after 4 conversions.
- range_shift=2 and model returns 400 (s=100 < 240) -> shift to 1 (retry); next 400 gives s=200, still below LO_LIMIT, so shift goes to 0; next gives sample=400, range_sat=0.
- Model never replies, TIMEOUT=200 -> timeout_fault rises 200 cycles after start_conv with no sample_valid; the next start occurs on the period boundary; an err_clear pulse drops the flag.
- Assert reset while in CONVERT, then deliver conv_done -> all outputs 0, no sample_valid; after release with enable=1, the first start_conv comes 1 cycle after IDLE.

Source files
------------

// File: rtl/adc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : adc_sequencer
// Purpose  : Periodic dual-slope ADC conversion sequencer with conversion
//            watchdog and automatic down-ramp range shifting.
// Revision : 1.0 - initial release
// ============================================================================
module adc_sequencer #(
  parameter int unsigned PERIOD    = 650000,
  parameter int unsigned TIMEOUT   = 1300000,
  parameter int unsigned HI_LIMIT  = 1023,
  parameter int unsigned LO_LIMIT  = 240,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        err_clear,
  input  logic        conv_done,
  input  logic [19:0] down_ramp_time,
  output logic        start_conv,
  output logic [19:0] sample,
  output logic        sample_valid,
  output logic [1:0]  range_shift,
  output logic        range_sat,
  output logic        timeout_fault,
  output logic        busy
);

  localparam logic [20:0] c_period_last  = 21'(PERIOD - 1);
  localparam logic [20:0] c_timeout_last = 21'(TIMEOUT - 1);
  localparam logic [20:0] c_max_retry    = 21'(MAX_RETRY);
  localparam logic [19:0] c_hi_limit     = 20'(HI_LIMIT);
  localparam logic [19:0] c_lo_limit     = 20'(LO_LIMIT);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT    = 3'd1,
    S_START   = 3'd2,
    S_CONVERT = 3'd3,
    S_CHECK   = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [20:0] r_period_cnt;
  logic [20:0] r_wd_cnt;
  logic [20:0] r_retry;
  logic [19:0] r_latched;
  logic [19:0] r_sample;
  logic [1:0]  r_shift;
  logic        r_sample_valid;
  logic        r_range_sat;
  logic        r_fault;

  logic [19:0] w_shifted;
  logic        w_above;
  logic        w_below;
  logic        w_can_retry;
  logic        w_range_up;
  logic        w_range_dn;
  logic        w_accept;
  logic        w_timeout;

  assign w_shifted   = r_latched >> r_shift;
  assign w_above     = w_shifted > c_hi_limit;
  assign w_below     = w_shifted < c_lo_limit;
  assign w_can_retry = r_retry < c_max_retry;
  assign w_range_up  = w_above && (r_shift != 2'd3) && w_can_retry;
  assign w_range_dn  = !w_range_up && w_below && (r_shift != 2'd0) && w_can_retry;

  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable) w_next = S_START;
      end
      S_WAIT: begin
        if (!enable)                             w_next = S_IDLE;
        else if (r_period_cnt == c_period_last) w_next = S_START;
      end
      S_START: begin
        w_next = S_CONVERT;
      end
      S_CONVERT: begin
        // A conv_done arriving on the watchdog's last cycle still counts.
        if (conv_done) begin
          w_next = S_CHECK;
        end else if (r_wd_cnt == c_timeout_last) begin
          w_timeout = 1'b1;
          w_next    = enable ? S_WAIT : S_IDLE;
        end
      end
      S_CHECK: begin
        if (w_range_up || w_range_dn) begin
          w_next = S_START;
        end else begin
          w_accept = 1'b1;
          w_next   = enable ? S_WAIT : S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_period_cnt   <= '0;
      r_wd_cnt       <= '0;
      r_retry        <= '0;
      r_latched      <= '0;
      r_sample       <= '0;
      r_shift        <= '0;
      r_sample_valid <= 1'b0;
      r_range_sat    <= 1'b0;
      r_fault        <= 1'b0;
    end else begin
      r_state <= w_next;

      // Both counters restart on every entry to START, including retries.
      if (w_next == S_START)                r_period_cnt <= '0;
      else if (r_period_cnt == c_period_last) r_period_cnt <= '0;
      else                                  r_period_cnt <= r_period_cnt + 21'd1;

      if (w_next == S_START)
        r_wd_cnt <= '0;
      else if (r_state == S_START || r_state == S_CONVERT)
        r_wd_cnt <= r_wd_cnt + 21'd1;

      if (r_state == S_CONVERT && conv_done) r_latched <= down_ramp_time;

      if (r_state == S_CHECK && w_range_up) r_shift <= r_shift + 2'd1;
      if (r_state == S_CHECK && w_range_dn) r_shift <= r_shift - 2'd1;

      if (r_state == S_CHECK && (w_range_up || w_range_dn)) r_retry <= r_retry + 21'd1;
      else if (w_accept || w_timeout)                        r_retry <= '0;

      r_sample_valid <= w_accept;
      if (w_accept) begin
        r_sample    <= w_shifted;
        r_range_sat <= w_above || w_below;
      end

      if (w_timeout)      r_fault <= 1'b1;
      else if (err_clear) r_fault <= 1'b0;
    end
  end

  assign start_conv    = (r_state == S_START);
  assign busy          = (r_state == S_START) || (r_state == S_CONVERT) || (r_state == S_CHECK);
  assign sample        = r_sample;
  assign sample_valid  = r_sample_valid;
  assign range_shift   = r_shift;
  assign range_sat     = r_range_sat;
  assign timeout_fault = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_adc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_sequencer
// Purpose  : Self-checking bench for adc_sequencer with an ADC responder model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_sequencer;

  localparam int c_period  = 100;
  localparam int c_timeout = 200;
  localparam int c_hi      = 1023;
  localparam int c_lo      = 240;
  localparam int c_maxr    = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        err_clear;
  logic        conv_done;
  logic [19:0] down_ramp_time;
  logic        start_conv;
  logic [19:0] sample;
  logic        sample_valid;
  logic [1:0]  range_shift;
  logic        range_sat;
  logic        timeout_fault;
  logic        busy;

  adc_sequencer #(
    .PERIOD   (c_period),
    .TIMEOUT  (c_timeout),
    .HI_LIMIT (c_hi),
    .LO_LIMIT (c_lo),
    .MAX_RETRY(c_maxr)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .err_clear     (err_clear),
    .conv_done     (conv_done),
    .down_ramp_time(down_ramp_time),
    .start_conv    (start_conv),
    .sample        (sample),
    .sample_valid  (sample_valid),
    .range_shift   (range_shift),
    .range_sat     (range_sat),
    .timeout_fault (timeout_fault),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Responder and monitor state, all owned by the main process.
  int               cyc = 0;
  int               starts = 0;
  int               last_start = 0;
  int               done_cyc = 0;
  int               resp_cnt = 0;
  int               resp_idx = 0;
  int               resp_delay = 50;
  logic             resp_on = 1'b0;
  logic [3:0][19:0] resp_vals;
  int               svs = 0;
  int               sv_cyc = 0;
  logic [19:0]      sv_sample;
  logic             sv_sat;
  logic [1:0]       sv_shift;
  logic             sv_busy;
  logic             prev_sv = 1'b0;

  typedef struct {
    logic [3:0][19:0] raw;
    logic [19:0]      smp;
    logic             sat;
    logic [1:0]       sh;
    int               n;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic fail_bound(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: no DUT response within cycle budget", nm);
  endtask

  function automatic logic [3:0][19:0] mk4(input logic [19:0] a, input logic [19:0] b,
                                           input logic [19:0] c, input logic [19:0] d);
    logic [3:0][19:0] r;
    r[0] = a; r[1] = b; r[2] = c; r[3] = d;
    return r;
  endfunction

  // One negedge step: respond to start_conv after resp_delay cycles, record sample_valid.
  task automatic tick();
    @(negedge clk);
    cyc++;
    conv_done = 1'b0;
    if (start_conv) begin
      starts++;
      last_start = cyc;
      if (resp_on) resp_cnt = resp_delay;
    end else if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        conv_done      = 1'b1;
        down_ramp_time = resp_vals[2'(resp_idx)];
        resp_idx++;
        done_cyc = cyc;
      end
    end
    if (sample_valid) begin
      check("sv_single_pulse", 32'(prev_sv), 32'd0);
      svs++;
      sv_cyc    = cyc;
      sv_sample = sample;
      sv_sat    = range_sat;
      sv_shift  = range_shift;
      sv_busy   = busy;
    end
    prev_sv = sample_valid;
  endtask

  // Spec-level model: walk the conversions of one sample applying the re-range rules.
  task automatic ref_model(input logic [3:0][19:0] raws, input int sh_in, output int sh_out,
                           output int n, output logic [19:0] smp, output logic sat);
    int sh;
    int retry;
    bit fin;
    logic [19:0] s;
    sh = sh_in; retry = 0; fin = 0; n = 0; smp = '0; sat = 1'b0;
    for (int k = 0; k < 4 && !fin; k++) begin
      s = raws[k] >> sh;
      n = k + 1;
      if (int'(s) > c_hi && sh < 3 && retry < c_maxr) begin
        sh++; retry++;
      end else if (int'(s) < c_lo && sh > 0 && retry < c_maxr) begin
        sh--; retry++;
      end else begin
        smp = s;
        sat = (int'(s) > c_hi) || (int'(s) < c_lo);
        fin = 1;
      end
    end
    sh_out = sh;
  endtask

  task automatic run_txn(input string nm, input logic [3:0][19:0] raws, input int dly,
                         input bit chk_period, input logic [19:0] e_smp, input logic e_sat,
                         input logic [1:0] e_sh, input int e_n);
    int svs0, st0, first, prev_last;
    bit got;
    resp_vals = raws; resp_idx = 0; resp_delay = dly;
    svs0 = svs; st0 = starts; first = -1; prev_last = last_start; got = 0;
    for (int i = 0; i < 600 && !got; i++) begin
      tick();
      if (start_conv && first < 0) first = cyc;
      if (svs != svs0) got = 1;
    end
    if (!got) begin
      fail_bound(nm);
      return;
    end
    check({nm, ".sample"}, 32'(sv_sample), 32'(e_smp));
    check({nm, ".range_sat"}, 32'(sv_sat), 32'(e_sat));
    check({nm, ".range_shift"}, 32'(sv_shift), 32'(e_sh));
    check({nm, ".conversions"}, 32'(starts - st0), 32'(e_n));
    check({nm, ".valid_latency"}, 32'(sv_cyc - done_cyc), 32'd2);
    check({nm, ".retry_timing"}, 32'(sv_cyc - first), 32'(e_n * (dly + 2)));
    check({nm, ".busy_after"}, 32'(sv_busy), 32'd0);
    if (chk_period) check({nm, ".start_period"}, 32'(first - prev_last), 32'(c_period));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int model_shift, n, ts, ts2, svs0, st0, dly;
    logic [19:0] smp;
    logic        sat;
    logic [3:0][19:0] raws;
    bit seen;

    reset = 1'b1; enable = 1'b0; err_clear = 1'b0; conv_done = 1'b0; down_ramp_time = '0;
    repeat (3) tick();
    check("rst.start_conv", 32'(start_conv), 32'd0);
    check("rst.sample", 32'(sample), 32'd0);
    check("rst.sample_valid", 32'(sample_valid), 32'd0);
    check("rst.range_shift", 32'(range_shift), 32'd0);
    check("rst.range_sat", 32'(range_sat), 32'd0);
    check("rst.timeout_fault", 32'(timeout_fault), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    reset = 1'b0;
    repeat (3) tick();
    check("idle.no_start", 32'(starts), 32'd0);

    // Chained table: each entry starts from the previous entry's range_shift.
    vecs[0]  = '{mk4(20'd500, 0, 0, 0),                           20'd500,    1'b0, 2'd0, 1};
    vecs[1]  = '{mk4(20'd500, 0, 0, 0),                           20'd500,    1'b0, 2'd0, 1};
    vecs[2]  = '{mk4(20'd3000, 20'd1500, 0, 0),                   20'd750,    1'b0, 2'd1, 2};
    vecs[3]  = '{mk4(20'd4000, 20'd4000, 0, 0),                   20'd1000,   1'b0, 2'd2, 2};
    vecs[4]  = '{mk4(20'd400, 20'd400, 20'd400, 0),               20'd400,    1'b0, 2'd0, 3};
    vecs[5]  = '{mk4(20'hFFFFF, 20'hFFFFF, 20'hFFFFF, 20'hFFFFF), 20'h1FFFF,  1'b1, 2'd3, 4};
    vecs[6]  = '{mk4(20'd100, 20'd100, 20'd100, 20'd100),         20'd100,    1'b1, 2'd0, 4};
    vecs[7]  = '{mk4(20'd2000, 20'd200, 20'd2000, 20'd200),       20'd100,    1'b1, 2'd1, 4};
    vecs[8]  = '{mk4(20'd478, 20'd478, 0, 0),                     20'd478,    1'b0, 2'd0, 2};
    vecs[9]  = '{mk4(20'd1023, 0, 0, 0),                          20'd1023,   1'b0, 2'd0, 1};
    vecs[10] = '{mk4(20'd1024, 20'd1024, 0, 0),                   20'd512,    1'b0, 2'd1, 2};
    vecs[11] = '{mk4(20'd480, 0, 0, 0),                           20'd240,    1'b0, 2'd1, 1};
    vecs[12] = '{mk4(20'd0, 20'd0, 0, 0),                         20'd0,      1'b1, 2'd0, 2};

    enable = 1'b1; resp_on = 1'b1;
    for (int i = 0; i < 13; i++)
      run_txn($sformatf("vec%0d", i), vecs[i].raw, 50, i != 0,
              vecs[i].smp, vecs[i].sat, vecs[i].sh, vecs[i].n);
    model_shift = int'(vecs[12].sh);

    for (int t = 0; t < 25; t++) begin
      for (int k = 0; k < 4; k++)
        raws[k] = 20'($urandom & ((32'd1 << $urandom_range(1, 20)) - 32'd1));
      dly = int'($urandom_range(1, 90));
      ref_model(raws, model_shift, model_shift, n, smp, sat);
      run_txn($sformatf("rnd%0d", t), raws, dly, 1'b1, smp, sat, 2'(model_shift), n);
    end

    // Watchdog: no reply at all.
    resp_on = 1'b0;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin tick(); if (start_conv) seen = 1; end
    if (!seen) fail_bound("to.first_start");
    ts = cyc; svs0 = svs;
    seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin tick(); if (timeout_fault) seen = 1; end
    if (!seen) fail_bound("to.fault_rise");
    check("to.fault_latency", 32'(cyc - ts), 32'(c_timeout));
    check("to.no_sample", 32'(svs - svs0), 32'd0);
    seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin tick(); if (start_conv) seen = 1; end
    if (!seen) fail_bound("to.restart");
    check("to.restart_on_period", 32'(cyc - ts), 32'(3 * c_period));
    ts2 = cyc;
    err_clear = 1'b1; tick(); err_clear = 1'b0;
    check("to.err_clear", 32'(timeout_fault), 32'd0);
    enable = 1'b0;
    while (cyc < ts2 + c_timeout - 1) tick();
    err_clear = 1'b1; tick(); err_clear = 1'b0;
    check("to.set_wins", 32'(timeout_fault), 32'd1);
    check("to.idle_after_disable", 32'(busy), 32'd0);
    st0 = starts;
    repeat (150) tick();
    check("dis.no_start", 32'(starts - st0), 32'd0);
    check("dis.shift_retained", 32'(range_shift), 32'(model_shift));
    err_clear = 1'b1; tick(); err_clear = 1'b0;
    check("dis.err_clear", 32'(timeout_fault), 32'd0);

    // Asynchronous reset mid-conversion, then a late conv_done.
    enable = 1'b1;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin tick(); if (start_conv) seen = 1; end
    if (!seen) fail_bound("rc.start");
    repeat (10) tick();
    check("rc.busy_convert", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("rc.start_conv", 32'(start_conv), 32'd0);
    check("rc.sample", 32'(sample), 32'd0);
    check("rc.sample_valid", 32'(sample_valid), 32'd0);
    check("rc.range_shift", 32'(range_shift), 32'd0);
    check("rc.range_sat", 32'(range_sat), 32'd0);
    check("rc.timeout_fault", 32'(timeout_fault), 32'd0);
    check("rc.busy", 32'(busy), 32'd0);
    svs0 = svs;
    tick();
    conv_done = 1'b1; down_ramp_time = 20'h12345;
    repeat (4) tick();
    check("rc.late_done_ignored", 32'(svs - svs0), 32'd0);
    check("rc.sample_held", 32'(sample), 32'd0);
    reset = 1'b0;
    #1;
    check("rc.idle_no_start", 32'(start_conv), 32'd0);
    tick();
    check("rc.first_start", 32'(start_conv), 32'd1);
    enable = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
